// File: rtl/mem_stage.sv
// Memory stage: IDLE/ACCESS/RESP handshake between execute and a single-beat data bus.
// Optional MEM_MISALIGN_TRAP_EN flags misaligned half/word accesses instead of issuing them.
package mem_stage_pkg;
  typedef struct packed {
    logic       mem;
    logic       iop;
    logic [2:0] fcs_opcode;
  } control_s;
endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  control_s        i_control_signal,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_store_data,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic [3:0]      o_mem_wstrb,
  input  logic            i_mem_ack,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic            o_wb_valid,
  output logic [XLEN-1:0] o_wb_data,
  output control_s        o_control_signal,
  output logic            o_bus_error,
  output logic            o_misaligned
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e          st_q, st_d;
  control_s        ctrl_q, ctrl_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic            we_q, we_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            accept, in_reserved, in_mis;
  logic [1:0]      in_size;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_result;

  assign accept      = (st_q == StIdle) && i_valid;
  assign in_size     = i_control_signal.fcs_opcode[1:0];
  assign in_reserved = (i_control_signal.fcs_opcode == 3'b011) ||
                       (i_control_signal.fcs_opcode[2:1] == 2'b11);

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  assign in_mis = ((in_size == 2'b01) && i_addr[0]) || ((in_size == 2'b10) && (i_addr[1:0] != 2'b00));
  always_comb begin
    mis_d = mis_q;
    if (accept) mis_d = i_control_signal.mem && !in_reserved && in_mis;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) mis_q <= 1'b0;
    else         mis_q <= mis_d;
  end
  assign o_misaligned = mis_q;
`else
  assign in_mis       = 1'b0;
  assign o_misaligned = 1'b0;
`endif

  // Lane extraction uses the unaligned captured address; the bus only sees the word address.
  assign ld_byte = i_mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half = i_mem_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_result = '0;
    case (ctrl_q.fcs_opcode)
      3'b000:  ld_result = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_result = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b010:  ld_result = i_mem_rdata;
      3'b100:  ld_result = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_result = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_result = '0;
    endcase
  end

  always_comb begin
    st_d      = st_q;
    ctrl_d    = ctrl_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    we_d      = we_q;
    wb_data_d = wb_data_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    case (st_q)
      StIdle: begin
        if (i_valid) begin
          ctrl_d    = i_control_signal;
          err_d     = 1'b0;
          wb_data_d = '0;
          if (!i_control_signal.mem) begin
            wb_data_d = i_addr;
            st_d      = StResp;
          end else if (in_reserved || in_mis) begin
            st_d = StResp;
          end else begin
            st_d    = StAccess;
            cnt_d   = '0;
            addr_d  = i_addr;
            we_d    = i_control_signal.iop;
            wstrb_d = 4'b0000;
            wdata_d = '0;
            if (i_control_signal.iop) begin
              case (in_size)
                2'b00: begin
                  wstrb_d = 4'b0001 << i_addr[1:0];
                  wdata_d = {4{i_store_data[7:0]}};
                end
                2'b01: begin
                  wstrb_d = 4'b0011 << {i_addr[1], 1'b0};
                  wdata_d = {2{i_store_data[15:0]}};
                end
                default: begin
                  wstrb_d = 4'b1111;
                  wdata_d = i_store_data;
                end
              endcase
            end
          end
        end
      end
      StAccess: begin
        // Ack wins over a timeout landing in the same cycle.
        if (i_mem_ack) begin
          wb_data_d = ctrl_q.iop ? '0 : ld_result;
          st_d      = StResp;
        end else if (cnt_q == CntLast) begin
          err_d = 1'b1;
          st_d  = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp:  st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      st_q      <= StIdle;
      ctrl_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      we_q      <= 1'b0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      st_q      <= st_d;
      ctrl_q    <= ctrl_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      we_q      <= we_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_ready          = (st_q == StIdle);
  assign o_mem_req        = (st_q == StAccess);
  assign o_mem_we         = (st_q == StAccess) && we_q;
  assign o_mem_addr       = {addr_q[XLEN-1:2], 2'b00};
  assign o_mem_wdata      = wdata_q;
  assign o_mem_wstrb      = wstrb_q;
  assign o_wb_valid       = (st_q == StResp);
  assign o_wb_data        = wb_data_q;
  assign o_control_signal = ctrl_q;
  assign o_bus_error      = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Random + directed scoreboard bench for mem_stage with a reactive bus responder.
`timescale 1ns/1ps
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned TO   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_valid = 1'b0;
  logic              o_ready;
  control_s          i_ctrl = '0;
  logic [XLEN-1:0]   i_addr = '0;
  logic [XLEN-1:0]   i_sd = '0;
  logic              o_mem_req, o_mem_we;
  logic [XLEN-1:0]   o_mem_addr, o_mem_wdata;
  logic [3:0]        o_mem_wstrb;
  logic              auto_ack = 1'b0;
  logic              man_ack = 1'b0;
  logic              i_mem_ack;
  logic [XLEN-1:0]   i_mem_rdata = '0;
  logic              o_wb_valid;
  logic [XLEN-1:0]   o_wb_data;
  control_s          o_ctrl;
  logic              o_bus_error, o_misaligned;

  assign i_mem_ack = auto_ack | man_ack;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(XLEN), .MEM_TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_control_signal(i_ctrl), .i_addr(i_addr), .i_store_data(i_sd),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb), .i_mem_ack(i_mem_ack),
    .i_mem_rdata(i_mem_rdata), .o_wb_valid(o_wb_valid), .o_wb_data(o_wb_data),
    .o_control_signal(o_ctrl), .o_bus_error(o_bus_error), .o_misaligned(o_misaligned)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        mis;
    control_s    ctrl;
  } wb_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          delay;
    logic [31:0] rdata;
  } bus_t;

  wb_t  wb_q[$];
  bus_t bus_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   bus_auto = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", name, act, exp, $time);
    end
  endfunction

  function automatic control_s mk(bit mem, bit iop, logic [2:0] op);
    control_s c;
    c.mem = mem;
    c.iop = iop;
    c.fcs_opcode = op;
    return c;
  endfunction

  // Reference: what a single operation should do, from the architectural rules.
  function automatic void model(input control_s c, input logic [31:0] a, input logic [31:0] sd,
                                input logic [31:0] rd, input int delay,
                                output wb_t w, output bit bus, output bus_t b);
    int unsigned off, bv, hv;
    off = a % 4;
    w.ctrl = c; w.err = 1'b0; w.mis = 1'b0; w.data = 32'd0;
    bus = 1'b0;
    b.addr = 0; b.we = 0; b.wdata = 0; b.wstrb = 0; b.delay = delay; b.rdata = rd;
    if (!c.mem) begin
      w.data = a;
      return;
    end
    if (c.fcs_opcode == 3'b011 || c.fcs_opcode == 3'b110 || c.fcs_opcode == 3'b111) return;
`ifdef MEM_MISALIGN_TRAP_EN
    if ((c.fcs_opcode[1:0] == 2'b01 && off % 2 != 0) || (c.fcs_opcode[1:0] == 2'b10 && off != 0)) begin
      w.mis = 1'b1;
      return;
    end
`endif
    bus = 1'b1;
    b.addr = a - off;
    b.we = c.iop;
    if (c.iop) begin
      case (c.fcs_opcode[1:0])
        2'b00: begin b.wstrb = 4'(1 << off);           b.wdata = sd[7:0] * 32'h0101_0101; end
        2'b01: begin b.wstrb = 4'(3 << ((off / 2) * 2)); b.wdata = sd[15:0] * 32'h0001_0001; end
        default: begin b.wstrb = 4'hF; b.wdata = sd; end
      endcase
    end
    if (delay >= int'(TO)) begin
      w.err = 1'b1;
      return;
    end
    if (!c.iop) begin
      bv = (rd >> (8 * off)) & 32'hFF;
      hv = (rd >> (16 * (off / 2))) & 32'hFFFF;
      case (c.fcs_opcode)
        3'b000:  w.data = (bv >= 128) ? bv + 32'hFFFF_FF00 : bv;
        3'b001:  w.data = (hv >= 32768) ? hv + 32'hFFFF_0000 : hv;
        3'b010:  w.data = rd;
        3'b100:  w.data = bv;
        default: w.data = hv;
      endcase
    end
  endfunction

  task automatic issue(input control_s c, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rd, input int delay);
    wb_t  w;
    bus_t b;
    bit   bus;
    int   t = 0;
    @(negedge clk);
    while (!o_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", 32'(o_ready), 32'd1);
    if (!o_ready) return;
    model(c, a, sd, rd, delay, w, bus, b);
    wb_q.push_back(w);
    if (bus) bus_q.push_back(b);
    i_valid = 1'b1; i_ctrl = c; i_addr = a; i_sd = sd;
    @(posedge clk);
    #1;
    i_valid = 1'b0; i_ctrl = control_s'($urandom); i_addr = $urandom; i_sd = $urandom;
  endtask

  // Bus responder: checks each request against the model and acks after the planned delay.
  initial begin
    bit   in_req = 1'b0;
    int   cyc = 0;
    bus_t cur;
    forever begin
      @(negedge clk);
      auto_ack = 1'b0;
      i_mem_rdata = $urandom;
      if (!bus_auto || rst) begin
        in_req = 1'b0;
      end else if (o_mem_req) begin
        if (!in_req) begin
          if (bus_q.size() == 0) begin
            check("unexpected_req", 32'(o_mem_req), 32'd0);
          end else begin
            cur = bus_q.pop_front();
            in_req = 1'b1;
            cyc = 0;
          end
        end
        if (in_req) begin
          check("mem_addr", o_mem_addr, cur.addr);
          check("mem_we", 32'(o_mem_we), 32'(cur.we));
          if (cur.we) begin
            check("mem_wdata", o_mem_wdata, cur.wdata);
            check("mem_wstrb", 32'(o_mem_wstrb), 32'(cur.wstrb));
          end
          if (cyc >= int'(TO)) begin
            check("req_overstay", 32'(o_mem_req), 32'd0);
            in_req = 1'b0;
          end else if (cyc == cur.delay) begin
            auto_ack = 1'b1;
            i_mem_rdata = cur.rdata;
            in_req = 1'b0;
          end
          cyc++;
        end
      end else if (in_req) begin
        check("timeout_len", 32'(cyc), 32'(TO));
        in_req = 1'b0;
      end else begin
        auto_ack = ($urandom_range(0, 3) == 0);  // stray acks outside ACCESS
      end
    end
  end

  // Writeback monitor.
  initial begin
    wb_t w;
    forever begin
      @(negedge clk);
      if (!rst && o_wb_valid) begin
        if (wb_q.size() == 0) begin
          check("unexpected_wb", 32'(o_wb_valid), 32'd0);
        end else begin
          w = wb_q.pop_front();
          check("wb_data", o_wb_data, w.data);
          check("wb_bus_error", 32'(o_bus_error), 32'(w.err));
          check("wb_misaligned", 32'(o_misaligned), 32'(w.mis));
          check("wb_ctrl", 32'(o_ctrl), 32'(w.ctrl));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_req", 32'(o_mem_req), 32'd0);
    check("rst_we", 32'(o_mem_we), 32'd0);
    check("rst_wb_valid", 32'(o_wb_valid), 32'd0);
    check("rst_bus_error", 32'(o_bus_error), 32'd0);
    check("rst_misaligned", 32'(o_misaligned), 32'd0);
    check("rst_mem_addr", o_mem_addr, 32'd0);
    check("rst_mem_wdata", o_mem_wdata, 32'd0);
    check("rst_mem_wstrb", 32'(o_mem_wstrb), 32'd0);
    check("rst_wb_data", o_wb_data, 32'd0);
    check("rst_ctrl", 32'(o_ctrl), 32'd0);
    rst = 1'b0;

    // Reset during the second ACCESS cycle, then a late ack: nothing must be written back.
    @(negedge clk);
    i_valid = 1'b1; i_ctrl = mk(1, 0, 3'b010); i_addr = 32'h40;
    @(posedge clk);
    #1 i_valid = 1'b0;
    @(negedge clk);
    check("rstmid_req_c1", 32'(o_mem_req), 32'd1);
    @(negedge clk);
    check("rstmid_req_c2", 32'(o_mem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_req_drop", 32'(o_mem_req), 32'd0);
    rst = 1'b0;
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    repeat (3) begin
      check("rstmid_no_wb", 32'(o_wb_valid), 32'd0);
      check("rstmid_ready", 32'(o_ready), 32'd1);
      @(negedge clk);
    end

    bus_auto = 1'b1;
    issue(mk(1, 0, 3'b000), 32'h1003, 32'h0, 32'h80FF_FF11, 2);   // LB sign-extend
    issue(mk(1, 1, 3'b001), 32'h2002, 32'h0000_ABCD, 32'h0, 1);   // SH upper half
    issue(mk(0, 0, 3'b000), 32'h1234, 32'h0, 32'h0, 0);           // non-mem
    issue(mk(1, 0, 3'b010), 32'h5000, 32'h0, 32'hDEAD_BEEF, 10);  // timeout
    issue(mk(1, 0, 3'b010), 32'h5004, 32'h0, 32'hCAFE_F00D, 3);   // ack on last cycle
    issue(mk(1, 0, 3'b011), 32'h6000, 32'h0, 32'h0, 0);           // reserved
    issue(mk(1, 0, 3'b010), 32'h3002, 32'h0, 32'h1357_9BDF, 1);   // misaligned LW
    issue(mk(1, 1, 3'b000), 32'h7001, 32'h0000_005A, 32'h0, 0);   // SB lane 1
    issue(mk(1, 0, 3'b101), 32'h7002, 32'h0, 32'h8765_4321, 0);   // LHU upper half

    for (int i = 0; i < 300; i++) begin
      control_s c;
      c.mem = ($urandom_range(0, 3) != 0);
      c.iop = 1'($urandom_range(0, 1));
      c.fcs_opcode = 3'($urandom_range(0, 7));
      if (c.iop && (c.fcs_opcode == 3'b100 || c.fcs_opcode == 3'b101)) c.fcs_opcode[2] = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(c, $urandom, $urandom, $urandom, $urandom_range(0, 5));
    end

    t = 0;
    while ((wb_q.size() != 0 || bus_q.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("wb_drained", 32'(wb_q.size()), 32'd0);
    check("bus_drained", 32'(bus_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
